// File: rtl/mem_requester.sv
// rtl/mem_requester.sv - load/store sequencer for single-port memory controller (optional MEM_REQ_WRITE_VERIFY_EN)
module mem_requester #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_we,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              mem_write,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_data
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

    localparam logic [2:0] RD_LAST = 3'(RD_LAT);

    state_t     state;
    state_t     state_nxt;
    logic [2:0] rd_cnt;
    logic       lat_we;
    logic       accept;
    logic       rd_done;

    // mem_addr / mem_writedata double as the latched request address and data
    assign req_ready = rst && (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign rd_done   = (state == READ) && (rd_cnt == RD_LAST);

    // next-state selection
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (accept) state_nxt = req_we ? WRITE : READ;
`ifdef MEM_REQ_WRITE_VERIFY_EN
            WRITE: state_nxt = READ;
`else
            WRITE: state_nxt = RESP;
`endif
            READ:  if (rd_done) state_nxt = RESP;
            RESP:  if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // registered strobes, request latch, read counter and response fields
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_write     <= 1'b0;
            mem_read      <= 1'b0;
            mem_addr      <= '0;
            mem_writedata <= '0;
            rsp_valid     <= 1'b0;
            rsp_we        <= 1'b0;
            rsp_rdata     <= '0;
            rd_cnt        <= '0;
            lat_we        <= 1'b0;
        end else begin
            mem_write <= (state_nxt == WRITE);
            mem_read  <= (state_nxt == READ);
            rsp_valid <= (state_nxt == RESP);
            if (accept) begin
                lat_we   <= req_we;
                mem_addr <= req_addr;
                if (req_we) mem_writedata <= req_wdata;
            end
            // zero outside READ so every READ entry starts at 0; saturates at RD_LAST
            if (state != READ)        rd_cnt <= '0;
            else if (rd_cnt != RD_LAST) rd_cnt <= rd_cnt + 3'd1;
`ifndef MEM_REQ_WRITE_VERIFY_EN
            if (state == WRITE) begin
                rsp_we    <= 1'b1;
                rsp_rdata <= mem_writedata;
            end
`endif
            if (rd_done) begin
                rsp_we    <= lat_we;
                rsp_rdata <= mem_data;
            end
        end
    end

`ifdef MEM_REQ_WRITE_VERIFY_EN
    // read-back verify: flag a write whose read-back differs from the written data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         rsp_err <= 1'b0;
        else if (rd_done) rsp_err <= lat_we && (mem_data != mem_writedata);
    end
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_requester.sv
// tb/tb_mem_requester.sv - self-checking bench for mem_requester
module tb_mem_requester;

    localparam int RD_LAT = 2;
`ifdef MEM_REQ_WRITE_VERIFY_EN
    localparam bit VER = 1'b1;
`else
    localparam bit VER = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_we = 1'b0;
    logic [3:0] req_addr = 4'h0;
    logic [7:0] req_wdata = 8'h00;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic       rsp_we;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       mem_write;
    logic       mem_read;
    logic [3:0] mem_addr;
    logic [7:0] mem_writedata;
    logic [7:0] mem_data;

    mem_requester #(.ADDR_W(4), .DATA_W(8), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_write(mem_write), .mem_read(mem_read), .mem_addr(mem_addr),
        .mem_writedata(mem_writedata), .mem_data(mem_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    // memory controller stand-in: registered output, RD_LAT-stage read pipe
    logic [7:0] mem_arr [16];
    logic [7:0] pipe [RD_LAT];
    logic       force_zero = 1'b0;

    always @(posedge clk) begin
        if (mem_write) mem_arr[mem_addr] <= mem_writedata;
        pipe[0] <= mem_read ? mem_arr[mem_addr] : 8'hEE;
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end

    assign mem_data = force_zero ? 8'h00 : pipe[RD_LAT-1];

    // transaction-level reference: cycle offsets from acceptance
    logic [7:0] ref_mem [16];
    bit         m_busy = 1'b0;
    int         m_k = 0;
    logic       m_we = 1'b0;
    logic [7:0] m_wdata = 8'h00;
    logic [7:0] m_rdata = 8'h00;
    logic       m_err = 1'b0;
    logic [3:0] last_addr = 4'h0;
    logic [7:0] last_wdata = 8'h00;
    int         rs, resp_k;
    bit         e_w, e_r, e_v;

    always @(negedge clk) begin
        if (!rst) begin
            m_busy = 1'b0;
            last_addr = 4'h0;
            last_wdata = 8'h00;
            check("rst_req_ready", req_ready, 0);
            check("rst_mem_write", mem_write, 0);
            check("rst_mem_read", mem_read, 0);
            check("rst_mem_addr", mem_addr, 0);
            check("rst_mem_writedata", mem_writedata, 0);
            check("rst_rsp_valid", rsp_valid, 0);
            check("rst_rsp_we", rsp_we, 0);
            check("rst_rsp_rdata", rsp_rdata, 0);
            check("rst_rsp_err", rsp_err, 0);
        end else begin
            e_w = 1'b0; e_r = 1'b0; e_v = 1'b0;
            if (m_busy) begin
                rs = m_we ? 2 : 1;
                resp_k = (m_we && !VER) ? 2 : rs + RD_LAT + 1;
                e_w = m_we && (m_k == 1);
                e_r = !(m_we && !VER) && (m_k >= rs) && (m_k <= rs + RD_LAT);
                e_v = (m_k >= resp_k);
            end
            check("req_ready", req_ready, !m_busy);
            check("mem_write", mem_write, e_w);
            check("mem_read", mem_read, e_r);
            check("rsp_valid", rsp_valid, e_v);
            check("mem_addr", mem_addr, last_addr);
            check("mem_writedata", mem_writedata, last_wdata);
            if (e_v) begin
                check("rsp_we", rsp_we, m_we);
                check("rsp_rdata", rsp_rdata, m_rdata);
                check("rsp_err", rsp_err, m_err);
            end
            if (!m_busy) begin
                if (req_valid) begin
                    m_busy = 1'b1;
                    m_k = 1;
                    m_we = req_we;
                    m_wdata = req_wdata;
                    last_addr = req_addr;
                    if (req_we) begin
                        last_wdata = req_wdata;
                        ref_mem[req_addr] = req_wdata;
                        m_rdata = (VER && force_zero) ? 8'h00 : req_wdata;
                        m_err = VER && (m_rdata != req_wdata);
                    end else begin
                        m_rdata = ref_mem[req_addr];
                        m_err = 1'b0;
                    end
                end
            end else if (e_v && rsp_ready) begin
                m_busy = 1'b0;
            end else begin
                m_k++;
            end
        end
    end

    logic [3:0] seen_waddr;
    logic [7:0] seen_wdata;
    logic [3:0] seen_raddr;
    logic       seen_err;

    // issue one request with rsp_ready high; called just after a rising edge
    task automatic do_req(input logic we, input logic [3:0] a, input logic [7:0] d,
                          output logic [7:0] rd, output int lat, output int nw, output int nr);
        int guard;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("accept_wait", guard < 50, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0; nw = 0; nr = 0; guard = 0; rd = 8'h00;
        while (guard < 50) begin
            @(negedge clk);
            lat++;
            guard++;
            if (mem_write) begin
                nw++;
                seen_waddr = mem_addr;
                seen_wdata = mem_writedata;
            end
            if (mem_read) begin
                nr++;
                seen_raddr = mem_addr;
            end
            if (rsp_valid) break;
        end
        check("rsp_wait", guard < 50, 1);
        rd = rsp_rdata;
        seen_err = rsp_err;
        @(posedge clk); #1;
    endtask

    logic [7:0] rd;
    int lat, nw, nr, t0;

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst = 1'b0;
        @(negedge clk);
        check("reset_req_ready_lit", req_ready, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // single write 0x3/0xA5
        do_req(1'b1, 4'h3, 8'hA5, rd, lat, nw, nr);
        check("w1_strobe_cycles", nw, 1);
        check("w1_addr", seen_waddr, 4'h3);
        check("w1_data", seen_wdata, 8'hA5);
        check("w1_rdata", rd, 8'hA5);
        check("w1_latency", lat, VER ? RD_LAT + 3 : 2);

        // read back 0x3
        do_req(1'b0, 4'h3, 8'h00, rd, lat, nw, nr);
        check("r1_read_cycles", nr, 3);
        check("r1_write_cycles", nw, 0);
        check("r1_addr", seen_raddr, 4'h3);
        check("r1_latency", lat, 4);
        check("r1_rdata", rd, 8'hA5);

        // read with response back-pressure and an ignored request meanwhile
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'h3;
        @(negedge clk);
        @(posedge clk); #1;
        req_valid = 1'b0;
        t0 = 0;
        while (!rsp_valid && t0 < 50) begin
            @(negedge clk);
            t0++;
        end
        check("stall_rsp_wait", t0 < 50, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_rsp_valid", rsp_valid, 1);
            check("stall_rsp_rdata", rsp_rdata, 8'hA5);
            check("stall_req_ready", req_ready, 0);
            @(posedge clk); #1;
            req_valid = (i == 1); req_we = 1'b1; req_addr = 4'h9; req_wdata = 8'h11;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("stall_after_valid", rsp_valid, 0);
        check("stall_after_ready", req_ready, 1);
        @(posedge clk); #1;

        // back-to-back writes then reads over the whole address space
        t0 = cyc;
        for (int a = 0; a < 16; a++) do_req(1'b1, 4'(a), 8'(a) ^ 8'h5A, rd, lat, nw, nr);
        check("b2b_write_clocks", cyc - t0, 16 * (VER ? RD_LAT + 4 : 3));
        t0 = cyc;
        for (int a = 0; a < 16; a++) begin
            do_req(1'b0, 4'(a), 8'h00, rd, lat, nw, nr);
            check("b2b_readback", rd, 8'(a) ^ 8'h5A);
        end
        check("b2b_read_clocks", cyc - t0, 16 * (RD_LAT + 3));

        // reset during READ cycle 1
        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'h5;
        @(negedge clk);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("abort_mem_read", mem_read, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("abort_req_ready", req_ready, 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("abort_no_rsp", rsp_valid, 0);
        end
        @(posedge clk); #1;

        // write 0x7/0x3C, then again with the memory returning zeros
        do_req(1'b1, 4'h7, 8'h3C, rd, lat, nw, nr);
        check("v1_rdata", rd, 8'h3C);
        check("v1_err", seen_err, 0);
        force_zero = 1'b1;
        do_req(1'b1, 4'h7, 8'h3C, rd, lat, nw, nr);
        check("v2_rdata", rd, VER ? 8'h00 : 8'h3C);
        check("v2_err", seen_err, VER ? 1 : 0);
        force_zero = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_requester.md
Name: mem_requester

Overview:
- Initiator-side sequencer that drives the single-port 8-bit memory controller interface (write, read, addr, writedata in; data out) on behalf of the core.
- Accepts one load/store request at a time over a valid/ready handshake.
- Drives the memory strobes with correct timing, waits out the registered-output read latency, and returns the result over a valid/ready response channel.
- Sits between the core's load/store unit and the memory controller.

Parameters:
- ADDR_W, 4, memory address width.
- DATA_W, 8, data width.
- RD_LAT, 2, clocks from the first read cycle until mem_data is valid (output register enabled); legal range 1..7.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  requester can accept a request.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_W  request address.
- req_wdata  input  DATA_W  write data.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts response.
- rsp_we  output  1  kind of the completed request.
- rsp_rdata  output  DATA_W  read data; for writes, an echo of the written data.
- rsp_err  output  1  verify mismatch; see Optional Feature; otherwise 0.
- mem_write  output  1  to controller write (wre).
- mem_read  output  1  to controller read (oce).
- mem_addr  output  ADDR_W  to controller addr.
- mem_writedata  output  DATA_W  to controller writedata.
- mem_data  input  DATA_W  from controller data.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE.
  - All registered outputs clear to 0: mem_write, mem_read, mem_addr, mem_writedata, rsp_valid, rsp_we, rsp_rdata, rsp_err.
  - req_ready is 0 while rst is low.
- Reset mid-operation aborts the transaction: strobes drop immediately, no response is issued, and the latched request is discarded.
- FSM states: IDLE, WRITE, READ, RESP. All mem_* outputs are registered.
- IDLE:
  - req_ready = 1.
  - A handshake (req_valid & req_ready) latches req_we, req_addr and req_wdata.
  - Next state is WRITE if req_we = 1, else READ.
  - mem_write = 0 and mem_read = 0; mem_addr and mem_writedata hold their last values.
- WRITE: exactly one cycle.
  - mem_write = 1; mem_addr and mem_writedata = latched values; mem_read = 0.
  - Next state is RESP, with rsp_we = 1 and rsp_rdata = latched wdata.
- READ: lasts RD_LAT+1 cycles, numbered 0..RD_LAT by a 3-bit counter that is cleared on entry.
  - mem_read = 1 and mem_write = 0; mem_addr is held constant.
  - At the clock edge ending cycle RD_LAT, mem_data is captured into rsp_rdata, rsp_we = 0, and the next state is RESP.
- RESP:
  - rsp_valid = 1; rsp_we, rsp_rdata and rsp_err are stable until the handshake.
  - rsp_valid & rsp_ready moves to IDLE. rsp_valid falls in the next cycle.
  - req_ready rises in the cycle after the handshake, so there is no same-cycle request/response overlap.
- Throughput, with rsp_ready held high:
  - Write: 3 clocks per request (accept, WRITE, RESP).
  - Read: RD_LAT+3 clocks per request.
- Request inputs are ignored outside IDLE; req_ready = 0 there.
- The address is not checked; all 2^ADDR_W values are legal. The read counter saturates and never wraps within a transaction.
- mem_read and mem_write are never high in the same cycle.

Optional Feature:
- Macro: MEM_REQ_WRITE_VERIFY_EN.
- Defined: after WRITE the FSM enters READ at the same address instead of RESP (read-back verify).
  - At capture, mem_data is compared with the latched wdata; rsp_err = 1 on mismatch.
  - rsp_rdata = mem_data as read back; rsp_we = 1.
  - Write throughput becomes RD_LAT+4 clocks.
- Undefined: writes go WRITE to RESP directly, and rsp_err is tied to 0.

Test Plan:
- Reset release, then write addr 0x3 data 0xA5, rsp_ready = 1 -> mem_write high exactly one cycle with mem_addr = 0x3 and mem_writedata = 0xA5; then rsp_valid = 1, rsp_we = 1, rsp_rdata = 0xA5.
- Write 0x3/0xA5, then read 0x3 (RD_LAT = 2) -> mem_read high for 3 cycles with mem_addr = 0x3; rsp_rdata = 0xA5 and rsp_valid rises on the 4th cycle after the read is accepted.
- Read response with rsp_ready held low for 5 cycles -> rsp_valid and rsp_rdata stable throughout, req_ready = 0, and a req_valid pulse meanwhile is ignored.
- Back-to-back writes to 0x0..0xF with data = addr ^ 0x5A, then reads of all 16 addresses -> every readback matches, including addr 0xF and 0x0 wrap coverage.
- rst driven low in READ cycle 1 -> mem_read = 0 immediately, no rsp_valid ever, req_ready = 1 on the first cycle after release.
- With MEM_REQ_WRITE_VERIFY_EN defined: write 0x7/0x3C -> rsp_err = 0, rsp_rdata = 0x3C. With the memory model forced to return 0x00 -> rsp_err = 1.
